adjacency_map: RTL and testbench

ADJACENCY_MAP -- requirements
Module: adjacency_map

---
 rtl/graph_pkg.sv | 26 ++
 rtl/sdp_ram.sv | 29 ++
 rtl/adjacency_map.sv | 237 +++++++++++++++++++++++
 tb/tb_adjacency_map.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// Shared graph definitions: default table sizes, node/edge pointer types,
// the null next-pointer convention and the adjacency_map state encoding.
package graph_pkg;

  localparam int GRAPH_MAX_NODES = 1024;
  localparam int GRAPH_MAX_EDGES = 2048;
  localparam int GRAPH_NODE_W    = $clog2(GRAPH_MAX_NODES);
  localparam int GRAPH_EPTR_W    = $clog2(GRAPH_MAX_EDGES) + 1;

  typedef logic [GRAPH_NODE_W-1:0] node_t;
  typedef logic [GRAPH_EPTR_W-1:0] edge_addr_t;

  // A pointer one bit wider than the edge index with every bit set can never
  // address a stored edge, so all-ones marks the end of a list.
  localparam edge_addr_t EDGE_NULL = '1;

  typedef enum logic [2:0] {
    ST_BUILD   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HEAD_RD = 3'd2,
    ST_EDGE_RD = 3'd3,
    ST_PRESENT = 3'd4,
    ST_GAP     = 3'd5
  } adj_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (one-cycle) read. Contents are deliberately not reset.
module sdp_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port (returns the old word on a same-address write)
  always_ff @(posedge clk) begin
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/adjacency_map.sv
// Adjacency map: builds per-source linked lists of edges (LIFO) while in
// BUILD, then answers node queries by streaming the adjacent nodes.
// Optional build statistics outputs are enabled with ADJACENCY_MAP_STATS_EN.
module adjacency_map
  import graph_pkg::*;
#(
  parameter int MAX_NODES  = GRAPH_MAX_NODES,
  parameter int MAX_EDGES  = GRAPH_MAX_EDGES,
  parameter int NODE_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  decoding_done,
  input  logic                  edge_valid,
  input  logic [NODE_WIDTH-1:0] src_node,
  input  logic [NODE_WIDTH-1:0] dst_node,
  input  logic                  query_valid,
  output logic                  query_ready,
  input  logic [NODE_WIDTH-1:0] query_data,
  output logic                  reply_valid,
  input  logic                  reply_ready,
  output logic [NODE_WIDTH-1:0] reply_data,
  output logic                  reply_last,
  output logic                  reply_no_edges_found
`ifdef ADJACENCY_MAP_STATS_EN
  ,
  output logic [$clog2(MAX_EDGES):0] edge_count,
  output logic                       edge_overflow
`endif
);

  localparam int EI_W  = (MAX_EDGES > 1) ? $clog2(MAX_EDGES) : 1;  // edge index
  localparam int EP_W  = EI_W + 1;                                 // index + null
  localparam int CNT_W = $clog2(MAX_EDGES) + 1;
  localparam int EW    = NODE_WIDTH + EP_W;                        // {dst, next}
  localparam logic [EP_W-1:0] NULL_PTR = {EP_W{EDGE_NULL[0]}};

  adj_state_t r_state, w_state_next;

  logic [MAX_NODES-1:0]  r_head_valid;
  logic [CNT_W-1:0]      r_count;

  // Build pipeline stage 1 (head read returned, table writes happen here)
  logic                  r_s1_valid;
  logic [NODE_WIDTH-1:0] r_s1_src;
  logic [NODE_WIDTH-1:0] r_s1_dst;
  logic [EI_W-1:0]       r_s1_idx;
  logic                  r_s1_hv;

  // Copy of last cycle's head write; covers the RAM read-during-write window
  logic                  r_fwd_valid;
  logic [NODE_WIDTH-1:0] r_fwd_src;
  logic [EI_W-1:0]       r_fwd_idx;

  logic [NODE_WIDTH-1:0] r_q_node;
  logic [EI_W-1:0]       r_next;
  logic                  r_reply_valid;
  logic [NODE_WIDTH-1:0] r_reply_data;
  logic                  r_reply_last;
  logic                  r_reply_no_edges;

  logic                  w_src_in_range;
  logic                  w_edge_accept;
  logic                  w_q_in_range;
  logic                  w_q_has_edges;
  logic [EI_W-1:0]       w_head_rdata;
  logic [EI_W-1:0]       w_s1_old_head;
  logic [EP_W-1:0]       w_s1_next;
  logic [EI_W-1:0]       w_head_ptr;
  logic [EW-1:0]         w_edge_rdata;
  logic [NODE_WIDTH-1:0] w_edge_dst;
  logic [EP_W-1:0]       w_edge_next;
  logic                  w_head_rd_en;
  logic [NODE_WIDTH-1:0] w_head_rd_addr;
  logic                  w_edge_rd_en;
  logic [EI_W-1:0]       w_edge_rd_addr;

  assign w_src_in_range = (int'(src_node) < MAX_NODES);
  assign w_edge_accept  = (r_state == ST_BUILD) && edge_valid && w_src_in_range &&
                          (r_count < CNT_W'(MAX_EDGES));
  assign w_q_in_range   = (int'(query_data) < MAX_NODES);
  assign w_q_has_edges  = w_q_in_range && r_head_valid[query_data];

  assign w_s1_old_head  = (r_fwd_valid && (r_fwd_src == r_s1_src)) ? r_fwd_idx : w_head_rdata;
  assign w_s1_next      = r_s1_hv ? {1'b0, w_s1_old_head} : NULL_PTR;
  assign w_head_ptr     = (r_fwd_valid && (r_fwd_src == r_q_node)) ? r_fwd_idx : w_head_rdata;
  assign w_edge_dst     = w_edge_rdata[EW-1:EP_W];
  assign w_edge_next    = w_edge_rdata[EP_W-1:0];

  sdp_ram #(.DEPTH(MAX_NODES), .WIDTH(EI_W), .AW(NODE_WIDTH)) u_head_ram (
    .clk       (clk),
    .i_wr_en   (r_s1_valid),
    .i_wr_addr (r_s1_src),
    .i_wr_data (r_s1_idx),
    .i_rd_en   (w_head_rd_en),
    .i_rd_addr (w_head_rd_addr),
    .o_rd_data (w_head_rdata)
  );

  sdp_ram #(.DEPTH(MAX_EDGES), .WIDTH(EW), .AW(EI_W)) u_edge_ram (
    .clk       (clk),
    .i_wr_en   (r_s1_valid),
    .i_wr_addr (r_s1_idx),
    .i_wr_data ({r_s1_dst, w_s1_next}),
    .i_rd_en   (w_edge_rd_en),
    .i_rd_addr (w_edge_rd_addr),
    .o_rd_data (w_edge_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BUILD;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BUILD:   if (decoding_done) w_state_next = ST_IDLE;
      ST_IDLE:    if (query_valid) w_state_next = w_q_has_edges ? ST_HEAD_RD : ST_PRESENT;
      ST_HEAD_RD: w_state_next = ST_EDGE_RD;
      ST_EDGE_RD: w_state_next = ST_PRESENT;
      ST_PRESENT: if (reply_ready) w_state_next = r_reply_last ? ST_IDLE : ST_GAP;
      ST_GAP:     w_state_next = ST_PRESENT;
      default:    w_state_next = ST_BUILD;
    endcase
  end

  // Table read controls per state
  always_comb begin
    w_head_rd_en   = 1'b0;
    w_head_rd_addr = src_node;
    w_edge_rd_en   = 1'b0;
    w_edge_rd_addr = w_head_ptr;
    case (r_state)
      ST_BUILD: w_head_rd_en = w_edge_accept;
      ST_IDLE: begin
        w_head_rd_en   = query_valid && w_q_has_edges;
        w_head_rd_addr = query_data;
      end
      ST_HEAD_RD: w_edge_rd_en = 1'b1;
      ST_PRESENT: begin
        w_edge_rd_en   = reply_ready && !r_reply_last;
        w_edge_rd_addr = r_next;
      end
      default: ;
    endcase
  end

  // Edge counter and head-valid flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_head_valid <= '0;
    end else if (w_edge_accept) begin
      r_count                <= r_count + 1'b1;
      r_head_valid[src_node] <= 1'b1;
    end
  end

  // Build pipeline and head-write forwarding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_src    <= '0;
      r_s1_dst    <= '0;
      r_s1_idx    <= '0;
      r_s1_hv     <= 1'b0;
      r_fwd_valid <= 1'b0;
      r_fwd_src   <= '0;
      r_fwd_idx   <= '0;
    end else begin
      r_s1_valid  <= w_edge_accept;
      r_s1_src    <= src_node;
      r_s1_dst    <= dst_node;
      r_s1_idx    <= r_count[EI_W-1:0];
      r_s1_hv     <= r_head_valid[src_node];
      r_fwd_valid <= r_s1_valid;
      r_fwd_src   <= r_s1_src;
      r_fwd_idx   <= r_s1_idx;
    end
  end

  // Reply registers: load a beat, drop valid on handshake, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_node         <= '0;
      r_next           <= '0;
      r_reply_valid    <= 1'b0;
      r_reply_data     <= '0;
      r_reply_last     <= 1'b0;
      r_reply_no_edges <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (query_valid) begin
          r_q_node <= query_data;
          if (!w_q_has_edges) begin
            r_reply_valid    <= 1'b1;
            r_reply_data     <= '0;
            r_reply_last     <= 1'b1;
            r_reply_no_edges <= 1'b1;
          end
        end
        ST_EDGE_RD, ST_GAP: begin
          r_reply_valid    <= 1'b1;
          r_reply_data     <= w_edge_dst;
          r_reply_last     <= (w_edge_next == NULL_PTR);
          r_reply_no_edges <= 1'b0;
          r_next           <= w_edge_next[EI_W-1:0];
        end
        ST_PRESENT: if (reply_ready) r_reply_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign query_ready          = (r_state == ST_IDLE);
  assign reply_valid          = r_reply_valid;
  assign reply_data           = r_reply_data;
  assign reply_last           = r_reply_last;
  assign reply_no_edges_found = r_reply_no_edges;

`ifdef ADJACENCY_MAP_STATS_EN
  logic r_overflow;

  // Sticky flag for any edge strobe dropped while building
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             r_overflow <= 1'b0;
    else if ((r_state == ST_BUILD) && edge_valid && !w_edge_accept) r_overflow <= 1'b1;
  end

  assign edge_count    = r_count;
  assign edge_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_adjacency_map.sv
// Testbench for adjacency_map: randomized builds and queries checked by a
// scoreboard fed from an edge-list reference model.
module tb_adjacency_map;

  localparam int MAX_NODES = 12;
  localparam int MAX_EDGES = 8;
  localparam int NW        = 4;
  localparam int CNT_W     = $clog2(MAX_EDGES) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          decoding_done = 1'b0;
  logic          edge_valid = 1'b0;
  logic [NW-1:0] src_node = '0;
  logic [NW-1:0] dst_node = '0;
  logic          query_valid = 1'b0;
  logic          query_ready;
  logic [NW-1:0] query_data = '0;
  logic          reply_valid;
  logic          reply_ready = 1'b0;
  logic [NW-1:0] reply_data;
  logic          reply_last;
  logic          reply_no_edges_found;
`ifdef ADJACENCY_MAP_STATS_EN
  logic [CNT_W-1:0] edge_count;
  logic             edge_overflow;
`endif

  adjacency_map #(.MAX_NODES(MAX_NODES), .MAX_EDGES(MAX_EDGES), .NODE_WIDTH(NW)) dut (
    .clk(clk), .rst_n(rst_n), .decoding_done(decoding_done), .edge_valid(edge_valid),
    .src_node(src_node), .dst_node(dst_node), .query_valid(query_valid),
    .query_ready(query_ready), .query_data(query_data), .reply_valid(reply_valid),
    .reply_ready(reply_ready), .reply_data(reply_data), .reply_last(reply_last),
    .reply_no_edges_found(reply_no_edges_found)
`ifdef ADJACENCY_MAP_STATS_EN
    , .edge_count(edge_count), .edge_overflow(edge_overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [NW-1:0] data; logic last; logic noedge; } beat_t;
  typedef struct packed { logic [NW-1:0] s; logic [NW-1:0] d; } edge_t;

  int     errors = 0;
  int     checks = 0;
  beat_t  sb[$];
  edge_t  model_edges[$];
  bit     in_build = 1'b1;
  bit     exp_ovf = 1'b0;
  int     ready_mode = 0;
  beat_t  last_beat = '0;
  beat_t  stall_beat = '0;
  bit     stall_pending = 1'b0;
  int     gap_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reply_ready driver
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       reply_ready = 1'b1;
      1:       reply_ready = 1'($urandom_range(0, 1));
      default: reply_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every reply handshake and checks holds
  always @(negedge clk) begin
    beat_t cur;
    beat_t exp;
    if (rst_n) begin
      cur = {reply_data, reply_last, reply_no_edges_found};
      if (gap_cnt == 2) begin
        check("gap_valid_low", int'(reply_valid), 0);
        gap_cnt = 1;
      end else if (gap_cnt == 1) begin
        check("next_beat_at_h2", int'(reply_valid), 1);
        gap_cnt = 0;
      end
      if (stall_pending) begin
        check("stall_valid", int'(reply_valid), 1);
        check("stall_payload", int'(cur), int'(stall_beat));
      end
      if (!reply_valid) begin
        check("hold_payload", int'(cur), int'(last_beat));
      end else if (reply_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data=%0d last=%0d expected no beat", reply_data, reply_last);
        end else begin
          exp = sb.pop_front();
          check("beat_data", int'(reply_data), int'(exp.data));
          check("beat_last", int'(reply_last), int'(exp.last));
          check("beat_noedge", int'(reply_no_edges_found), int'(exp.noedge));
          $display("beat data=%0d last=%0d noedge=%0d", reply_data, reply_last, reply_no_edges_found);
        end
        last_beat = cur;
        if (!reply_last) gap_cnt = 2;
      end
      stall_pending = reply_valid && !reply_ready;
      stall_beat    = cur;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; edge_valid = 1'b0; decoding_done = 1'b0; query_valid = 1'b0;
    #1;
    check("rst_reply_valid", int'(reply_valid), 0);
    check("rst_query_ready", int'(query_ready), 0);
    check("rst_reply_last", int'(reply_last), 0);
    check("rst_noedge", int'(reply_no_edges_found), 0);
    check("rst_reply_data", int'(reply_data), 0);
`ifdef ADJACENCY_MAP_STATS_EN
    check("rst_edge_count", int'(edge_count), 0);
    check("rst_overflow", int'(edge_overflow), 0);
`endif
    sb.delete(); model_edges.delete();
    last_beat = '0; stall_pending = 1'b0; gap_cnt = 0;
    in_build = 1'b1; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset done");
  endtask

  // One build-phase cycle; called at posedge+1
  task automatic send(input bit ev, input int s, input int d, input bit done);
    edge_t e;
    if (in_build) check("build_query_ready", int'(query_ready), 0);
    edge_valid = ev; src_node = NW'(s); dst_node = NW'(d); decoding_done = done;
    if (ev && in_build) begin
      if (model_edges.size() < MAX_EDGES) begin
        e.s = NW'(s); e.d = NW'(d);
        model_edges.push_back(e);
      end else exp_ovf = 1'b1;
    end
    $display("edge ev=%0d %0d->%0d done=%0d stored=%0d", ev, s, d, done, model_edges.size());
    if (done) in_build = 1'b0;
    @(posedge clk); #1;
    edge_valid = 1'b0; decoding_done = 1'b0;
    if (done) check("query_ready_after_done", int'(query_ready), 1);
  endtask

  task automatic check_stats();
`ifdef ADJACENCY_MAP_STATS_EN
    check("edge_count", int'(edge_count), model_edges.size());
    check("edge_overflow", int'(edge_overflow), int'(exp_ovf));
`endif
  endtask

  // Issue one query, push expected beats, check first-beat latency, drain
  task automatic do_query(input int q, input int stall);
    int n;
    int lat;
    int dsts[$];
    beat_t b;
    n = 0;
    while (!query_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!query_ready) begin
      checks++; errors++;
      $display("FAIL query_ready_timeout: got 0 expected 1");
      return;
    end
    if (q < MAX_NODES)
      for (int i = model_edges.size() - 1; i >= 0; i--)
        if (int'(model_edges[i].s) == q) dsts.push_back(int'(model_edges[i].d));
    if (dsts.size() == 0) begin
      b.data = '0; b.last = 1'b1; b.noedge = 1'b1; sb.push_back(b);
    end else begin
      for (int i = 0; i < dsts.size(); i++) begin
        b.data = NW'(dsts[i]); b.last = (i == dsts.size() - 1); b.noedge = 1'b0;
        sb.push_back(b);
      end
    end
    $display("query node=%0d expect %0d beat(s)", q, sb.size());
    query_valid = 1'b1; query_data = NW'(q);
    @(posedge clk); #1;
    query_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!reply_valid && lat < 10);
    check("first_beat_latency", lat, (dsts.size() == 0) ? 1 : 3);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      ready_mode = 0;
    end
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int ne;
    do_reset();
    ready_mode = 0;

    // Three edges from node 0, one edge stored with done, one dropped after
    send(1, 0, 1, 0);
    send(1, 0, 2, 0);
    send(1, 0, 3, 0);
    send(1, 4, 9, 1);
    send(1, 4, 10, 0);
    check_stats();
    do_query(0, 0);
    do_query(4, 0);
    do_query(5, 0);
    do_query(13, 0);
    ready_mode = 2;
    do_query(0, 10);
    ready_mode = 1;
    do_query(0, 0);
    do_query(4, 0);

    // Reset in the middle of a reply
    ready_mode = 2;
    query_valid = 1'b1; query_data = 4'd0;
    @(posedge clk); #1;
    query_valid = 1'b0;
    ne = 0;
    while (!reply_valid && ne < 10) begin @(negedge clk); ne++; end
    check("midreply_valid_seen", int'(reply_valid), 1);
    do_reset();
    ready_mode = 0;
    send(1, 7, 8, 0);
    send(0, 0, 0, 1);
    do_query(0, 0);
    do_query(7, 0);

    // Capacity boundary: ten strobes into eight slots
    do_reset();
    for (int i = 0; i < 10; i++) send(1, 2, i, i == 9);
    check_stats();
    ready_mode = 1;
    do_query(2, 0);

    // Randomized sessions
    for (int k = 0; k < 6; k++) begin
      do_reset();
      ready_mode = $urandom_range(0, 1);
      ne = $urandom_range(0, 11);
      for (int i = 0; i < ne; i++) begin
        if ($urandom_range(0, 3) == 0) send(0, 0, 0, 0);
        send(1, $urandom_range(0, MAX_NODES - 1), $urandom_range(0, 15), 0);
      end
      send($urandom_range(0, 1), $urandom_range(0, MAX_NODES - 1), $urandom_range(0, 15), 1);
      if ($urandom_range(0, 1) == 1) send(1, $urandom_range(0, MAX_NODES - 1), 5, 0);
      check_stats();
      for (int j = 0; j < 8; j++) do_query($urandom_range(0, 15), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
